// File: rtl/mem_wb_stage_pipe.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_pipe
//
// MEM -> WB pipeline register for the 32-bit MIPS pipeline, built as a chain
// of STAGES register slots (legal range 1..4). Slot 0 captures the Memory
// stage; the last slot drives the Writeback outputs. Every slot carries a
// valid bit, so bubbles and flushed instructions travel with their fields
// masked.
//
// Optional feature macro: MEM_WB_PERF_CNT_EN
//   When defined, RetireCnt / BubbleCnt outputs are added. They count
//   non-stalled edges with and without a valid instruction in the last slot.
//   Both saturate and clear only on RST.
//
// Ports
//   CLK         in   clock, rising edge
//   RST         in   synchronous active-high reset
//   StallW      in   hold every slot, drop the M-stage inputs
//   FlushW      in   invalidate every slot (wins over StallW)
//   ValidM      in   M-stage inputs carry a real instruction
//   RegWriteM   in   instruction writes the register file
//   MemtoRegM   in   result comes from memory data
//   ReadDataM   in   data-memory read value      [DATA_WIDTH]
//   ALUOutM     in   ALU result                  [DATA_WIDTH]
//   WriteRegM   in   destination register index  [REG_ADDR_WIDTH]
//   HazRegA/B   in   decode source registers for hazard lookup
//   ValidW      out  last slot holds a valid instruction
//   RegWriteW   out  qualified write enable (never for $zero)
//   MemtoRegW   out  raw registered MemtoReg
//   ReadDataW   out  registered memory data
//   ALUOutW     out  registered ALU result
//   WriteRegW   out  registered destination index
//   ResultW     out  writeback value (mux of ReadDataW / ALUOutW)
//   HazHitA/B   out  some slot holds a pending write to HazRegA/B
//   RetireCnt   out  (MEM_WB_PERF_CNT_EN only) retired instructions
//   BubbleCnt   out  (MEM_WB_PERF_CNT_EN only) bubble edges
// ---------------------------------------------------------------------------
module mem_wb_stage_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int STAGES         = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      StallW,
    input  logic                      FlushW,
    input  logic                      ValidM,
    input  logic                      RegWriteM,
    input  logic                      MemtoRegM,
    input  logic [DATA_WIDTH-1:0]     ReadDataM,
    input  logic [DATA_WIDTH-1:0]     ALUOutM,
    input  logic [REG_ADDR_WIDTH-1:0] WriteRegM,
    input  logic [REG_ADDR_WIDTH-1:0] HazRegA,
    input  logic [REG_ADDR_WIDTH-1:0] HazRegB,
    output logic                      ValidW,
    output logic                      RegWriteW,
    output logic                      MemtoRegW,
    output logic [DATA_WIDTH-1:0]     ReadDataW,
    output logic [DATA_WIDTH-1:0]     ALUOutW,
    output logic [REG_ADDR_WIDTH-1:0] WriteRegW,
    output logic [DATA_WIDTH-1:0]     ResultW,
    output logic                      HazHitA,
    output logic                      HazHitB
`ifdef MEM_WB_PERF_CNT_EN
    ,
    output logic [31:0]               RetireCnt,
    output logic [31:0]               BubbleCnt
`endif
);

    localparam int LAST = STAGES - 1;

    logic                      r_valid    [STAGES];
    logic                      r_regwrite [STAGES];
    logic                      r_memtoreg [STAGES];
    logic [DATA_WIDTH-1:0]     r_rdata    [STAGES];
    logic [DATA_WIDTH-1:0]     r_alu      [STAGES];
    logic [REG_ADDR_WIDTH-1:0] r_wreg     [STAGES];

    logic w_shift;
    logic w_hit_a;
    logic w_hit_b;

    // A flush moves the data fields like a normal shift even under stall;
    // only the valid bits are forced low, so the fields stay masked.
    assign w_shift = FlushW | ~StallW;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < STAGES; i++) begin
                r_valid[i]    <= 1'b0;
                r_regwrite[i] <= 1'b0;
                r_memtoreg[i] <= 1'b0;
                r_rdata[i]    <= '0;
                r_alu[i]      <= '0;
                r_wreg[i]     <= '0;
            end
        end else if (w_shift) begin
            r_valid[0]    <= ValidM & ~FlushW;
            r_regwrite[0] <= RegWriteM;
            r_memtoreg[0] <= MemtoRegM;
            r_rdata[0]    <= ReadDataM;
            r_alu[0]      <= ALUOutM;
            r_wreg[0]     <= WriteRegM;
            for (int i = STAGES - 1; i > 0; i--) begin
                r_valid[i]    <= r_valid[i-1] & ~FlushW;
                r_regwrite[i] <= r_regwrite[i-1];
                r_memtoreg[i] <= r_memtoreg[i-1];
                r_rdata[i]    <= r_rdata[i-1];
                r_alu[i]      <= r_alu[i-1];
                r_wreg[i]     <= r_wreg[i-1];
            end
        end
    end

    // Hazard lookup looks only at registered slots; a write to $zero never
    // counts, which also makes HazReg = 0 always miss.
    always_comb begin
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (r_valid[i] && r_regwrite[i] && (r_wreg[i] != '0)) begin
                if (r_wreg[i] == HazRegA) w_hit_a = 1'b1;
                if (r_wreg[i] == HazRegB) w_hit_b = 1'b1;
            end
        end
    end

    assign ValidW    = r_valid[LAST];
    assign RegWriteW = r_valid[LAST] & r_regwrite[LAST] & (r_wreg[LAST] != '0);
    assign MemtoRegW = r_memtoreg[LAST];
    assign ReadDataW = r_rdata[LAST];
    assign ALUOutW   = r_alu[LAST];
    assign WriteRegW = r_wreg[LAST];
    assign ResultW   = r_memtoreg[LAST] ? r_rdata[LAST] : r_alu[LAST];
    assign HazHitA   = w_hit_a;
    assign HazHitB   = w_hit_b;

`ifdef MEM_WB_PERF_CNT_EN
    logic [31:0] r_retire_cnt;
    logic [31:0] r_bubble_cnt;

    // Counts follow the last slot as seen before the edge; flush does not
    // interfere, stall freezes both.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_retire_cnt <= '0;
            r_bubble_cnt <= '0;
        end else if (!StallW) begin
            if (r_valid[LAST]) begin
                if (r_retire_cnt != 32'hFFFF_FFFF) r_retire_cnt <= r_retire_cnt + 32'd1;
            end else begin
                if (r_bubble_cnt != 32'hFFFF_FFFF) r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign RetireCnt = r_retire_cnt;
    assign BubbleCnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_stage_pipe.sv
module tb_mem_wb_stage_pipe;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        known;
    } slot_t;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [31:0] res;
        logic [4:0]  wr;
        logic        ha;
        logic        hb;
        logic        known;
        logic [31:0] rc;
        logic [31:0] bc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        rst, stall, flush, vm, rwm, m2rm;
    logic [31:0] rdm, alum;
    logic [4:0]  wrm, haza, hazb;

    logic        valid_w [3];
    logic        regw_w  [3];
    logic        m2r_w   [3];
    logic [31:0] rdata_w [3];
    logic [31:0] alu_w   [3];
    logic [4:0]  wreg_w  [3];
    logic [31:0] res_w   [3];
    logic        hita_w  [3];
    logic        hitb_w  [3];
    logic [31:0] rcnt_w  [3];
    logic [31:0] bcnt_w  [3];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_wb_stage_pipe #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .STAGES(g + 1)) u_dut (
            .CLK       (CLK),
            .RST       (rst),
            .StallW    (stall),
            .FlushW    (flush),
            .ValidM    (vm),
            .RegWriteM (rwm),
            .MemtoRegM (m2rm),
            .ReadDataM (rdm),
            .ALUOutM   (alum),
            .WriteRegM (wrm),
            .HazRegA   (haza),
            .HazRegB   (hazb),
            .ValidW    (valid_w[g]),
            .RegWriteW (regw_w[g]),
            .MemtoRegW (m2r_w[g]),
            .ReadDataW (rdata_w[g]),
            .ALUOutW   (alu_w[g]),
            .WriteRegW (wreg_w[g]),
            .ResultW   (res_w[g]),
            .HazHitA   (hita_w[g]),
            .HazHitB   (hitb_w[g])
`ifdef MEM_WB_PERF_CNT_EN
            ,
            .RetireCnt (rcnt_w[g]),
            .BubbleCnt (bcnt_w[g])
`endif
        );
`ifndef MEM_WB_PERF_CNT_EN
        assign rcnt_w[g] = '0;
        assign bcnt_w[g] = '0;
`endif
    end

    // Reference model: each pipeline is a queue of in-flight instructions,
    // front = newest, back = the one presented at writeback.
    slot_t       mq   [3][$];
    exp_t        expq [3][$];
    logic [31:0] rc   [3];
    logic [31:0] bc   [3];
    bit          init_done = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic exp_t predict(int d);
        exp_t  e;
        slot_t s;
        s = mq[d][mq[d].size() - 1];
        e.v     = s.v;
        e.rw    = s.v && s.rw && (s.wr != 0);
        e.m2r   = s.m2r;
        e.rd    = s.rd;
        e.alu   = s.alu;
        e.wr    = s.wr;
        e.res   = s.m2r ? s.rd : s.alu;
        e.known = s.known;
        e.ha    = 1'b0;
        e.hb    = 1'b0;
        for (int k = 0; k < mq[d].size(); k++) begin
            if (mq[d][k].v && mq[d][k].rw && mq[d][k].wr != 0) begin
                if (mq[d][k].wr == haza) e.ha = 1'b1;
                if (mq[d][k].wr == hazb) e.hb = 1'b1;
            end
        end
        e.rc = rc[d];
        e.bc = bc[d];
        return e;
    endfunction

    task automatic model_edge();
        slot_t s, z;
        z = '0;
        z.known = 1'b1;
        s.v = vm; s.rw = rwm; s.m2r = m2rm; s.rd = rdm; s.alu = alum; s.wr = wrm; s.known = 1'b1;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                mq[d].delete();
                for (int k = 0; k <= d; k++) mq[d].push_back(z);
                rc[d] = 0;
                bc[d] = 0;
            end else begin
                if (!stall) begin
                    if (mq[d][mq[d].size() - 1].v) begin
                        if (rc[d] != 32'hFFFF_FFFF) rc[d] = rc[d] + 1;
                    end else begin
                        if (bc[d] != 32'hFFFF_FFFF) bc[d] = bc[d] + 1;
                    end
                end
                if (flush) begin
                    // Flushed fields are not pinned down, so they are not compared.
                    mq[d].push_front(s);
                    void'(mq[d].pop_back());
                    for (int k = 0; k < mq[d].size(); k++) begin
                        mq[d][k].v     = 1'b0;
                        mq[d][k].known = 1'b0;
                    end
                end else if (!stall) begin
                    mq[d].push_front(s);
                    void'(mq[d].pop_back());
                end
            end
        end
        if (rst) init_done = 1;
    endtask

    task automatic step();
        if (init_done) begin
            for (int d = 0; d < 3; d++) expq[d].push_back(predict(d));
        end
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic r, input logic s, input logic f, input logic v,
                          input logic rw, input logic m2r, input logic [31:0] rd,
                          input logic [31:0] alu, input logic [4:0] wr,
                          input logic [4:0] ha, input logic [4:0] hb);
        rst = r; stall = s; flush = f; vm = v; rwm = rw; m2rm = m2r;
        rdm = rd; alum = alu; wrm = wr; haza = ha; hazb = hb;
    endtask

    task automatic rand_data();
        vm = 1'($urandom); rwm = 1'($urandom); m2rm = 1'($urandom);
        rdm = $urandom; alum = $urandom; wrm = 5'($urandom_range(0, 7));
    endtask

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s stages=%0d t=%0t: got %h expected %h", name, d + 1, $time, act, exp);
        end
    endtask

    // Monitor: the DUTs present their writeback view every cycle.
    always @(negedge CLK) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (expq[d].size() > 0) begin
                e = expq[d].pop_front();
                chk("ValidW", d, 32'(valid_w[d]), 32'(e.v));
                chk("RegWriteW", d, 32'(regw_w[d]), 32'(e.rw));
                chk("HazHitA", d, 32'(hita_w[d]), 32'(e.ha));
                chk("HazHitB", d, 32'(hitb_w[d]), 32'(e.hb));
                if (e.known) begin
                    chk("MemtoRegW", d, 32'(m2r_w[d]), 32'(e.m2r));
                    chk("ReadDataW", d, rdata_w[d], e.rd);
                    chk("ALUOutW", d, alu_w[d], e.alu);
                    chk("WriteRegW", d, 32'(wreg_w[d]), 32'(e.wr));
                    chk("ResultW", d, res_w[d], e.res);
                end
`ifdef MEM_WB_PERF_CNT_EN
                chk("RetireCnt", d, rcnt_w[d], e.rc);
                chk("BubbleCnt", d, bcnt_w[d], e.bc);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            rand_data();
            stall = 1'($urandom); flush = 1'($urandom);
            step();
        end
        // latency: one ALU write to r8, then bubbles
        set_in(0, 0, 0, 1, 1, 0, 32'h5555_0000, 32'h0000_1234, 5'd8, 5'd8, 5'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd8, 5'd0);
            step();
        end
        // stall / flush: memory load in flight
        set_in(0, 0, 0, 1, 1, 1, 32'hDEAD_BEEF, 32'h0000_0042, 5'd3, 5'd3, 5'd1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd1);
        step();
        for (int i = 0; i < 3; i++) begin
            rand_data();
            stall = 1'b1;
            step();
        end
        rand_data();
        stall = 1'b1; flush = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd1);
            step();
        end
        // write to $zero
        set_in(0, 0, 0, 1, 1, 0, 0, 32'h0000_00AA, 5'd0, 5'd0, 5'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
            step();
        end
        // hazard lookup: r4, r9, r4 in flight
        set_in(0, 0, 0, 1, 1, 0, 0, 32'h4, 5'd4, 5'd9, 5'd7); step();
        set_in(0, 0, 0, 1, 1, 0, 0, 32'h9, 5'd9, 5'd9, 5'd7); step();
        set_in(0, 0, 0, 1, 1, 0, 0, 32'h4, 5'd4, 5'd9, 5'd7); step();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd7);
            step();
        end
        // performance counters: reset, 10 alternating edges, 4 stalled edges
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
        step();
        for (int i = 0; i < 10; i++) begin
            set_in(0, 0, 0, (i % 2 == 0), 1, 0, 0, 32'(i), 5'(i + 1), 5'd2, 5'd3);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            rand_data();
            stall = 1'b1;
            step();
        end
        // randomized traffic including mid-pipeline resets
        for (int i = 0; i < 600; i++) begin
            rand_data();
            rst   = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 20);
            flush = ($urandom_range(0, 99) < 5);
            haza  = 5'($urandom_range(0, 7));
            hazb  = 5'($urandom_range(0, 7));
            step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
        step();
        @(negedge CLK);
        #1;
        for (int d = 0; d < 3; d++) chk("scoreboard_drained", d, 32'(expq[d].size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage_pipe.md
Name: mem_wb_stage_pipe

Overview:
- Parametrised MEM→WB pipeline register for the 32-bit MIPS pipeline.
- Carries the control and data fields of each instruction from the Memory stage to the Writeback stage through STAGES register slots. Extra slots cover deeper data-memory latency.
- Adds a per-slot valid bit, stall, flush, $zero write suppression, a writeback result mux, and hazard lookup of the destination registers still in flight.

Parameters:
- DATA_WIDTH, 32, width of ReadData, ALUOut and Result.
- REG_ADDR_WIDTH, 5, width of the destination register index.
- STAGES, 1, number of register slots between M and W; legal range 1..4.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- StallW  input  1  hold every slot.
- FlushW  input  1  invalidate every slot.
- ValidM  input  1  the Memory-stage inputs carry a real instruction.
- RegWriteM  input  1  instruction writes the register file.
- MemtoRegM  input  1  result is selected from memory data.
- ReadDataM  input  DATA_WIDTH  data-memory read value.
- ALUOutM  input  DATA_WIDTH  ALU result.
- WriteRegM  input  REG_ADDR_WIDTH  destination register index.
- HazRegA  input  REG_ADDR_WIDTH  decode source register A, used for hazard lookup.
- HazRegB  input  REG_ADDR_WIDTH  decode source register B, used for hazard lookup.
- ValidW  output  1  last slot holds a valid instruction.
- RegWriteW  output  1  qualified register-file write enable.
- MemtoRegW  output  1  registered MemtoReg.
- ReadDataW  output  DATA_WIDTH  registered memory data.
- ALUOutW  output  DATA_WIDTH  registered ALU result.
- WriteRegW  output  REG_ADDR_WIDTH  registered destination index.
- ResultW  output  DATA_WIDTH  writeback value.
- HazHitA  output  1  a pending write in any slot targets HazRegA.
- HazHitB  output  1  a pending write in any slot targets HazRegB.

Behaviour:
- Reset: synchronous, active-high on RST. On RST=1 at a rising CLK edge, every slot's valid bit and all fields clear to 0. Result: ValidW=0, RegWriteW=0, MemtoRegW=0, ReadDataW=0, ALUOutW=0, WriteRegW=0, ResultW=0, HazHitA=0, HazHitB=0.
- Priority per edge: RST > FlushW > StallW > normal shift.
- Normal shift (StallW=0):
  - slot0 ← {ValidM, RegWriteM, MemtoRegM, ReadDataM, ALUOutM, WriteRegM};
  - slot i ← slot i-1 for i = 1..STAGES-1.
- Latency: an input accepted at edge n appears on the W outputs after edge n+STAGES-1, i.e. STAGES edges total. STAGES=1 gives the classic single register.
- Stall (StallW=1, FlushW=0): all slots hold. Inputs presented in that cycle are dropped; the upstream stage holds them.
- Flush (FlushW=1): all valid bits clear at the next edge, regardless of StallW. Data fields may still load as in a normal shift, but are masked by valid=0.
- Bubble: ValidM=0 enters a slot with valid=0. Fields are still captured, and masked.
- Output qualification (combinational from the last slot):
  - RegWriteW = valid & regwrite & (WriteReg != 0); writes to $zero are never issued.
  - MemtoRegW is raw.
  - ValidW = valid of the last slot.
- ResultW = MemtoRegW ? ReadDataW : ALUOutW. Purely combinational, no extra latency.
- Hazard lookup (combinational from registered state only; no path from M-stage inputs):
  - HazHitA = OR over all slots of (valid & regwrite & WriteReg != 0 & WriteReg == HazRegA).
  - HazHitB is the same against HazRegB.
  - HazReg = 0 always yields 0.
- Reset arriving mid-pipeline discards every in-flight instruction; no partial writeback occurs.

Optional Feature:
- Macro: MEM_WB_PERF_CNT_EN.
- Defined:
  - adds outputs RetireCnt [31:0] and BubbleCnt [31:0];
  - on each edge with RST=0 and StallW=0: RetireCnt += 1 if ValidW=1, else BubbleCnt += 1;
  - both counters saturate at 32'hFFFF_FFFF, clear only on RST, and are unaffected by FlushW.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: RST=1 for 2 edges with random inputs → all outputs 0; HazHitA=HazHitB=0 for HazRegA=HazRegB=5.
- Latency (STAGES=1 and STAGES=3): ValidM=1, RegWriteM=1, MemtoRegM=0, ALUOutM=32'h0000_1234, WriteRegM=8 → after exactly STAGES edges: RegWriteW=1, WriteRegW=8, ResultW=32'h1234; earlier cycles ValidW=0.
- Stall/flush (STAGES=2): load ReadDataM=32'hDEAD_BEEF, MemtoRegM=1; StallW=1 for 3 edges → outputs frozen; then FlushW=1 together with StallW=1 → next edge ValidW=0, RegWriteW=0.
- $zero write: ValidM=1, RegWriteM=1, WriteRegM=0 → RegWriteW=0 at output; HazHitA=0 for HazRegA=0.
- Hazard (STAGES=3): valid writes to regs 4, 9, 4 in successive cycles → HazRegA=9 gives HazHitA=1 while reg 9 is in any slot, 0 after it drains; HazRegB=7 always gives 0.
- Perf (MEM_WB_PERF_CNT_EN defined, STAGES=1): 10 edges with alternating ValidM=1/0, then StallW=1 for 4 edges → retire/bubble counts advance only on non-stalled edges, one per edge according to ValidW, summing to 10 (RST released one edge before, so the first edge counts a bubble); no change during stall.
